// File: rtl/priority_encoder_reg.sv
// Registered priority encoder: sticky pending register, lowest unmasked index
// presented as a binary code under a valid/ack handshake.
module priority_encoder_reg #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clken,
  input  logic [2**WIDTH-1:0]   req,
  input  logic [2**WIDTH-1:0]   mask,
  input  logic                  ack,
  output logic                  valid,
  output logic [WIDTH-1:0]      code,
  output logic                  pend_any
);

  localparam int N = 2**WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_pend;
  logic             r_valid;
  logic [WIDTH-1:0] r_code;
  logic             r_pend_any;

  logic [N-1:0]     w_clr;
  logic             w_cand_vld;
  logic [WIDTH-1:0] w_cand_idx;

  // Scan from the top down so the lowest qualifying index is the last to win.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i] && !mask[i]) begin
        w_cand_vld = 1'b1;
        w_cand_idx = WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_valid && ack) w_clr[r_code] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_pend_any <= 1'b0;
    end else if (clken) begin
      // A request in the same cycle as its ack re-sets the bit (set wins).
      r_pend     <= (r_pend & ~w_clr) | req;
      r_pend_any <= |r_pend;
      case (r_state)
        IDLE, GAP: begin
          if (w_cand_vld) begin
            r_code  <= w_cand_idx;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end else begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        PRESENT: begin
          if (ack) begin
            r_valid <= 1'b0;
            r_state <= GAP;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign valid    = r_valid;
  assign code     = r_code;
  assign pend_any = r_pend_any;

endmodule

// File: tb/tb_priority_encoder_reg.sv
// Scoreboard bench for priority_encoder_reg (WIDTH=4): expected codes are
// queued as requests are driven and popped as the DUT presents them.
module tb_priority_encoder_reg;

  localparam int WIDTH = 4;
  localparam int N     = 2**WIDTH;

  logic             clk;
  logic             rst_n;
  logic             clken;
  logic [N-1:0]     req;
  logic [N-1:0]     mask;
  logic             ack;
  logic             valid;
  logic [WIDTH-1:0] code;
  logic             pend_any;

  int n_cmp;
  int n_fail;
  int exp_q[$];

  priority_encoder_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .valid    (valid),
    .code     (code),
    .pend_any (pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = valid;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      tick();
      ok = valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clken = 1'b1; req = '0; mask = '0; ack = 1'b0;
    tick(); tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (code !== 4'd0) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", code); end
    n_cmp++; if (pend_any !== 1'b0) begin n_fail++; $display("FAIL reset_pend_any got=%b exp=0", pend_any); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int e;
    req = 16'h0020; exp_q.push_back(5);
    tick();
    req = '0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_latency1 valid got=%b exp=0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", valid); end
    e = exp_q.pop_front();
    n_cmp++; if (code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL single_code got=%0d exp=%0d", code, e); end
    n_cmp++; if (pend_any !== 1'b1) begin n_fail++; $display("FAIL single_pend_any got=%b exp=1", pend_any); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_ack_valid got=%b exp=0", valid); end
    tick();
    n_cmp++; if (pend_any !== 1'b0) begin n_fail++; $display("FAIL single_pend_clear got=%b exp=0", pend_any); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid got=%b exp=0", valid); end
  endtask

  task automatic test_priority();
    int e;
    req = 16'h8000; exp_q.push_back(15);
    tick();
    req = '0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL prio_first got=%b/%0d exp=1/%0d", valid, code, e); end
    req = 16'h0001; exp_q.push_back(0);
    tick();
    req = '0;
    n_cmp++; if (valid !== 1'b1 || code !== 4'd15) begin n_fail++; $display("FAIL prio_no_preempt got=%b/%0d exp=1/15", valid, code); end
    tick();
    n_cmp++; if (valid !== 1'b1 || code !== 4'd15) begin n_fail++; $display("FAIL prio_hold got=%b/%0d exp=1/15", valid, code); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap got=%b exp=0", valid); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL prio_second got=%b/%0d exp=1/%0d", valid, code, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_mask();
    int e;
    mask = 16'h0004;
    req  = 16'h0084; exp_q.push_back(7);
    tick();
    req = '0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL mask_first got=%b/%0d exp=1/%0d", valid, code, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mask_blocked valid got=%b exp=0", valid); end
    n_cmp++; if (pend_any !== 1'b1) begin n_fail++; $display("FAIL mask_pend_any got=%b exp=1", pend_any); end
    mask = '0; exp_q.push_back(2);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL mask_released got=%b/%0d exp=1/%0d", valid, code, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_collision();
    int e;
    req = 16'h0008; exp_q.push_back(3);
    tick();
    req = '0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL coll_first got=%b/%0d exp=1/%0d", valid, code, e); end
    ack = 1'b1; req = 16'h0008; exp_q.push_back(3);
    tick();
    ack = 1'b0; req = '0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL coll_gap got=%b exp=0", valid); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL coll_repeat got=%b/%0d exp=1/%0d", valid, code, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0 || pend_any !== 1'b0) begin n_fail++; $display("FAIL coll_drain got=%b/%b exp=0/0", valid, pend_any); end
  endtask

  task automatic test_back_to_back();
    int e;
    bit ok;
    req = 16'h00F0; ack = 1'b1;
    for (int k = 4; k < 8; k++) exp_q.push_back(k);
    tick();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(4, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("FAIL b2b_timeout got=valid0 exp=valid1 item=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL b2b_code got=%0d exp=%0d", code, e); end
      end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b exp=0 item=%0d", valid, k); end
    end
    ack = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0 || pend_any !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b/%b exp=0/0", valid, pend_any); end
  endtask

  task automatic test_freeze();
    int e;
    req = 16'h0006; exp_q.push_back(1); exp_q.push_back(2);
    tick();
    req = '0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL frz_setup got=%b/%0d exp=1/%0d", valid, code, e); end
    clken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req = 16'h0101 | 16'($urandom_range(0, 65535));
      ack = k[0];
      tick();
      n_cmp++;
      if (valid !== 1'b1 || code !== 4'd1 || pend_any !== 1'b1 || dut.r_pend !== 16'h0006) begin
        n_fail++;
        $display("FAIL frz_hold got=%b/%0d/%b/%h exp=1/1/1/0006 cyc=%0d", valid, code, pend_any, dut.r_pend, k);
      end
    end
    clken = 1'b1; req = '0; ack = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b1 || code !== 4'd1) begin n_fail++; $display("FAIL frz_resume got=%b/%0d exp=1/1", valid, code); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL frz_next got=%b/%0d exp=1/%0d", valid, code, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
    n_cmp++; if (valid !== 1'b0 || pend_any !== 1'b0) begin n_fail++; $display("FAIL frz_lost got=%b/%b exp=0/0", valid, pend_any); end
  endtask

  task automatic test_reset_mid();
    int e;
    req = 16'h8600; exp_q.push_back(9);
    tick();
    req = '0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (valid !== 1'b1 || code !== e[WIDTH-1:0]) begin n_fail++; $display("FAIL rstm_setup got=%b/%0d exp=1/%0d", valid, code, e); end
    rst_n = 1'b0; clken = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0 || code !== 4'd0 || pend_any !== 1'b0) begin n_fail++; $display("FAIL rstm_clear got=%b/%0d/%b exp=0/0/0", valid, code, pend_any); end
    rst_n = 1'b1; clken = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (valid !== 1'b0 || pend_any !== 1'b0) begin n_fail++; $display("FAIL rstm_quiet got=%b/%b exp=0/0 cyc=%0d", valid, pend_any, k); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; clken = 1'b1; req = '0; mask = '0; ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_collision();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
